// File: rtl/snn_tx_pkg.sv
// Shared constants and FSM state type for the neuron-layer word-serial transmitters.
package snn_tx_pkg;

   localparam int WORD_W       = 32;
   localparam int HIDDEN_WORDS = 15;
   localparam int OUTPUT_WORDS = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      END   = 2'd3
   } tx_state_t;

endpackage

// File: rtl/neuron_load_tx_if.sv
// Request, word-memory and stream signals of one neuron_load_tx channel.
interface neuron_load_tx_if
   import snn_tx_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 15
);
   localparam int NW_W = $clog2(MAX_WORDS + 1);

   logic              i_start;
   logic [ADDR_W-1:0] i_base_addr;
   logic [NW_W-1:0]   i_num_words;
   logic              o_idle;
   logic              o_mem_en;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [WORD_W-1:0] i_mem_rdata;
   logic [WORD_W-1:0] o_data;
   logic              o_data_start;
   logic              o_data_ready;
   logic [WORD_W-1:0] o_checksum;

   modport master (
      output i_start, i_base_addr, i_num_words, i_mem_rdata,
      input  o_idle, o_mem_en, o_mem_addr, o_data, o_data_start, o_data_ready, o_checksum
   );

   modport slave (
      input  i_start, i_base_addr, i_num_words, i_mem_rdata,
      output o_idle, o_mem_en, o_mem_addr, o_data, o_data_start, o_data_ready, o_checksum
   );

endinterface

// File: rtl/neuron_load_tx.sv
// Word-serial frame transmitter for the neuron layer loaders: reads N words from word memory
// and streams them gap-free between a start and a ready pulse. Optional XOR checksum: NEURON_TX_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for a request with nonzero length
// READ  | one memory read issued per cycle
// DRAIN | reads done, last words still in the memory/output pipeline
// END   | data_ready pulse on the outputs
module neuron_load_tx
   import snn_tx_pkg::*;
#(
   parameter int MAX_WORDS = 15,
   parameter int ADDR_W    = 8
) (
   input  logic             sys_clk,
   input  logic             rst,
   neuron_load_tx_if.slave  bus
);
   localparam int NW_W = $clog2(MAX_WORDS + 1);

   tx_state_t         state_q, state_d;
   logic [NW_W-1:0]   rem_q, rem_d;
   logic [NW_W-1:0]   n_clamped;
   logic              accept;
   logic              mem_en_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              first_q, rfirst_q, rvld_q;
   logic [WORD_W-1:0] data_d;
   logic              ready_d;

   always_comb begin
      n_clamped = bus.i_num_words;
      if (int'(bus.i_num_words) > MAX_WORDS) n_clamped = NW_W'(MAX_WORDS);
   end

   assign accept     = (state_q == IDLE) && bus.i_start && (n_clamped != '0);
   assign bus.o_idle = (state_q == IDLE);

   // rem counts reads still to issue after the one currently on the memory port
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      mem_en_d   = 1'b0;
      mem_addr_d = bus.o_mem_addr;
      ready_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = READ;
               mem_en_d   = 1'b1;
               mem_addr_d = bus.i_base_addr;
               rem_d      = n_clamped - NW_W'(1);
            end
         end
         READ: begin
            if (rem_q == '0) begin
               state_d = DRAIN;
            end else begin
               mem_en_d   = 1'b1;
               mem_addr_d = bus.o_mem_addr + ADDR_W'(1);
               rem_d      = rem_q - NW_W'(1);
            end
         end
         DRAIN: begin
            if (!rvld_q) begin
               state_d = END;
               ready_d = 1'b1;
            end
         end
         END:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      data_d = rvld_q ? bus.i_mem_rdata : '0;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         rem_q            <= '0;
         first_q          <= 1'b0;
         rfirst_q         <= 1'b0;
         rvld_q           <= 1'b0;
         bus.o_mem_en     <= 1'b0;
         bus.o_mem_addr   <= '0;
         bus.o_data       <= '0;
         bus.o_data_start <= 1'b0;
         bus.o_data_ready <= 1'b0;
      end else begin
         state_q          <= state_d;
         rem_q            <= rem_d;
         first_q          <= accept;
         rfirst_q         <= first_q;
         rvld_q           <= bus.o_mem_en;
         bus.o_mem_en     <= mem_en_d;
         bus.o_mem_addr   <= mem_addr_d;
         bus.o_data       <= data_d;
         bus.o_data_start <= rfirst_q;
         bus.o_data_ready <= ready_d;
      end
   end

`ifdef NEURON_TX_CHECKSUM_EN
   logic [WORD_W-1:0] csum_acc;

   // accumulator is complete by the DRAIN->END edge, so publish it with the ready pulse
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         csum_acc       <= '0;
         bus.o_checksum <= '0;
      end else if (accept) begin
         csum_acc       <= '0;
         bus.o_checksum <= '0;
      end else begin
         if (rvld_q)  csum_acc       <= csum_acc ^ bus.i_mem_rdata;
         if (ready_d) bus.o_checksum <= csum_acc;
      end
   end
`else
   assign bus.o_checksum = '0;
`endif

endmodule

// File: tb/tb_neuron_load_tx.sv
// Scoreboard bench for neuron_load_tx: a 15-word hidden channel (a) and a 2-word output channel (b).
module tb_neuron_load_tx;
   import snn_tx_pkg::*;

   typedef struct {
      int          ch;
      logic [31:0] data;
      bit          start;
      bit          ready;
      int          cyc;
      logic [31:0] csum;
      logic [63:0] pk;
   } item_t;

   typedef struct {
      int          ch;
      logic [7:0]  addr;
      int          cyc;
   } areq_t;

   logic sys_clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_pass;

   item_t       exp_q[$];
   areq_t       addr_q[$];
   bit          in_frame[2];
   int          rdy_seen[2];
   logic [63:0] pk1;
   logic [31:0] mem[256];

   neuron_load_tx_if #(.ADDR_W(8), .MAX_WORDS(HIDDEN_WORDS)) ifa ();
   neuron_load_tx_if #(.ADDR_W(8), .MAX_WORDS(OUTPUT_WORDS)) ifb ();

   neuron_load_tx #(.MAX_WORDS(HIDDEN_WORDS), .ADDR_W(8)) dut_a (
      .sys_clk(sys_clk), .rst(rst), .bus(ifa)
   );
   neuron_load_tx #(.MAX_WORDS(OUTPUT_WORDS), .ADDR_W(8)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .bus(ifb)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // word memory, one-cycle read latency, one read port per channel
   always @(posedge sys_clk) begin
      if (ifa.o_mem_en) ifa.i_mem_rdata <= mem[ifa.o_mem_addr];
      if (ifb.o_mem_en) ifb.i_mem_rdata <= mem[ifb.o_mem_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic idle_of(input int ch);
      return (ch == 0) ? ifa.o_idle : ifb.o_idle;
   endfunction

   task automatic mon(input int ch, input logic st, input logic rd, input logic [31:0] d,
                      input logic [31:0] cs, input logic idle, input logic men,
                      input logic [7:0] ma);
      item_t e;
      areq_t r;
      if (men) begin
         if (addr_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_mem_en ch%0d: got addr %h expected no read (cycle %0d)", ch, ma, cyc);
         end else begin
            r = addr_q.pop_front();
            check("mem_ch", 64'(ch), 64'(r.ch));
            check("mem_addr", 64'(ma), 64'(r.addr));
            check("mem_cycle", 64'(cyc), 64'(r.cyc));
         end
      end
      if (st || rd || in_frame[ch] || d != '0) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output ch%0d: got data %h start %b ready %b expected none (cycle %0d)",
                     ch, d, st, rd, cyc);
         end else begin
            e = exp_q.pop_front();
            check("out_ch", 64'(ch), 64'(e.ch));
            check("out_word", {30'd0, d, st, rd}, {30'd0, e.data, e.start, e.ready});
            check("out_cycle", 64'(cyc), 64'(e.cyc));
            if (rd) begin
               rdy_seen[ch]++;
               check("idle_at_ready", 64'(idle), 64'(0));
               check("checksum", 64'(cs), 64'(e.csum));
               if (ch == 1) check("packed_b", pk1, e.pk);
            end else if (ch == 1) begin
               pk1 = {d, pk1[63:32]};
            end
         end
         if (rd) in_frame[ch] = 1'b0;
         else if (st) in_frame[ch] = 1'b1;
      end
   endtask

   always @(negedge sys_clk) begin
      if (rst) begin
         exp_q.delete();
         addr_q.delete();
         in_frame[0] = 1'b0;
         in_frame[1] = 1'b0;
      end else begin
         mon(0, ifa.o_data_start, ifa.o_data_ready, ifa.o_data, ifa.o_checksum, ifa.o_idle,
             ifa.o_mem_en, ifa.o_mem_addr);
         mon(1, ifb.o_data_start, ifb.o_data_ready, ifb.o_data, ifb.o_checksum, ifb.o_idle,
             ifb.o_mem_en, ifb.o_mem_addr);
      end
   end

   // issue a request; t is the cycle count seen just after the accepting edge
   task automatic launch(input int ch, input logic [7:0] base, input logic [3:0] nreq,
                         input int nexp, input logic [63:0] pk_exp, output int t);
      logic [31:0] cs;
      logic [7:0]  a;
      @(negedge sys_clk);
      if (ch == 0) begin
         ifa.i_start = 1'b1; ifa.i_base_addr = base; ifa.i_num_words = nreq;
      end else begin
         ifb.i_start = 1'b1; ifb.i_base_addr = base; ifb.i_num_words = nreq[1:0];
      end
      @(posedge sys_clk);
      #1;
      t = cyc;
      ifa.i_start = 1'b0;
      ifb.i_start = 1'b0;
      cs = '0;
      for (int k = 0; k < nexp; k++) begin
         a = base + 8'(k);
         addr_q.push_back('{ch, a, t + k});
         exp_q.push_back('{ch, mem[a], (k == 0), 1'b0, t + 2 + k, 32'h0, 64'h0});
         cs = cs ^ mem[a];
      end
`ifndef NEURON_TX_CHECKSUM_EN
      cs = '0;
`endif
      exp_q.push_back('{ch, 32'h0, 1'b0, 1'b1, t + 2 + nexp, cs, pk_exp});
   endtask

   task automatic finish_frame(input int ch, input int t, input int nexp, input bit poke);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         if (poke) ifa.i_start = (cyc == t + 4);
         if (idle_of(ch)) begin
            seen = 1'b1;
            break;
         end
      end
      ifa.i_start = 1'b0;
      check("idle_seen", 64'(seen), 64'(1));
      check("idle_cycle", 64'(cyc), 64'(t + 3 + nexp));
      repeat (4) @(negedge sys_clk);
      check("queues_drained", 64'(exp_q.size() + addr_q.size()), 64'(0));
   endtask

   task automatic run_frame(input int ch, input logic [7:0] base, input logic [3:0] nreq,
                            input int nexp, input logic [63:0] pk_exp, input bit poke);
      int t;
      launch(ch, base, nreq, nexp, pk_exp, t);
      finish_frame(ch, t, nexp, poke);
   endtask

   localparam logic [31:0] CS6 =
`ifdef NEURON_TX_CHECKSUM_EN
      32'h0FFF_F0F0;
`else
      32'h0000_0000;
`endif

   initial begin
      int t;
      n_chk = 0;
      n_pass = 0;
      pk1 = '0;
      rdy_seen[0] = 0;
      rdy_seen[1] = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A_0000 + 32'(i);
      for (int i = 0; i < 15; i++) mem[8'h10 + i] = 32'hA000_0000 + 32'(i);
      mem[8'h40] = 32'h1111_1111;
      mem[8'h41] = 32'h2222_2222;
      mem[8'hFE] = 32'hBEEF_00FE;
      mem[8'hFF] = 32'hBEEF_00FF;
      mem[8'h00] = 32'hBEEF_0000;
      mem[8'h01] = 32'hBEEF_0001;
      mem[8'h80] = 32'h0F0F_0000;
      mem[8'h81] = 32'h00F0_F0F0;
      ifa.i_start = 1'b0; ifa.i_base_addr = '0; ifa.i_num_words = '0;
      ifb.i_start = 1'b0; ifb.i_base_addr = '0; ifb.i_num_words = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_idle", 64'(ifa.o_idle), 64'(1));
      check("rst_mem_en", 64'(ifa.o_mem_en), 64'(0));
      check("rst_mem_addr", 64'(ifa.o_mem_addr), 64'(0));
      check("rst_data", 64'(ifa.o_data), 64'(0));
      check("rst_start_ready", {62'd0, ifa.o_data_start, ifa.o_data_ready}, 64'(0));
      check("rst_checksum", 64'(ifa.o_checksum), 64'(0));
      @(negedge sys_clk);
      rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // 15-word hidden frame from 0x10
      run_frame(0, 8'h10, 4'd15, 15, 64'h0, 1'b0);
      // 2-word output frame, packed as the output loader sees it
      run_frame(1, 8'h40, 4'd2, 2, 64'h2222_2222_1111_1111, 1'b0);

      // zero-length requests are ignored
      @(negedge sys_clk);
      ifa.i_start = 1'b1; ifa.i_num_words = 4'd0;
      ifb.i_start = 1'b1; ifb.i_num_words = 2'd0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         check("num0_idle_a", 64'(ifa.o_idle), 64'(1));
         check("num0_idle_b", 64'(ifb.o_idle), 64'(1));
      end
      ifa.i_start = 1'b0;
      ifb.i_start = 1'b0;

      // oversize length clamps to MAX_WORDS (20 does not fit the 4-bit hidden port; use 3 on the 2-word channel)
      run_frame(1, 8'h40, 4'd3, 2, 64'h2222_2222_1111_1111, 1'b0);

      // address wraps modulo 256
      run_frame(0, 8'hFE, 4'd4, 4, 64'h0, 1'b0);

      // start pulse mid-frame is dropped
      run_frame(0, 8'h10, 4'd15, 15, 64'h0, 1'b1);

      // reset mid-frame discards the rest of the frame
      launch(0, 8'h10, 4'd15, 15, 64'h0, t);
      repeat (7) @(posedge sys_clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_mem_en", 64'(ifa.o_mem_en), 64'(0));
      check("midrst_data", 64'(ifa.o_data), 64'(0));
      check("midrst_start_ready", {62'd0, ifa.o_data_start, ifa.o_data_ready}, 64'(0));
      check("midrst_mem_addr", 64'(ifa.o_mem_addr), 64'(0));
      check("midrst_idle", 64'(ifa.o_idle), 64'(1));
      @(posedge sys_clk);
      #2 rst = 1'b0;
      rdy_seen[0] = 0;
      repeat (25) @(negedge sys_clk);
      check("midrst_no_ready", 64'(rdy_seen[0]), 64'(0));
      check("midrst_idle_after", 64'(ifa.o_idle), 64'(1));

      // checksum of a 2-word frame, then held while idle
      run_frame(1, 8'h80, 4'd2, 2, 64'h00F0_F0F0_0F0F_0000, 1'b0);
      check("checksum_hold", 64'(ifb.o_checksum), 64'(CS6));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
